// File: rtl/trace_fifo.sv
// Trace byte FIFO with a drain sequencer that feeds a UART serializer over a
// start/done handshake; dropped pushes raise a sticky overflow flag.
module trace_fifo #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ACK_TO = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     ovf_o,
  input  logic                     ovf_clr_i,
  output logic [WIDTH-1:0]         tx_data_o,
  output logic                     tx_start_o,
  input  logic                     tx_done_i
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(ACK_TO + 1);

  typedef enum logic [1:0] {StIdle, StAck, StBusy} state_e;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, empty_q, ovf_q;
  logic [WIDTH-1:0] tx_data_q;
  logic             tx_start_q;
  logic [TW-1:0]    to_cnt_q;
  state_e           state_q;

  logic push, pop, drop;

  // Push qualifies on the registered full flag, so a pop in the same cycle
  // cannot make room for a push arriving at full.
  assign push = wr_en_i && !full_q;
  assign drop = wr_en_i && full_q;
  assign pop  = (state_q == StIdle) && !empty_q && tx_done_i;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      full_q  <= (count_d == CW'(DEPTH));
      empty_q <= (count_d == '0);
      if (drop) begin
        ovf_q <= 1'b1;
      end else if (ovf_clr_i) begin
        ovf_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      to_cnt_q   <= '0;
    end else begin
      tx_start_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            tx_data_q  <= mem_q[rd_ptr_q];
            tx_start_q <= 1'b1;
            to_cnt_q   <= '0;
            state_q    <= StAck;
          end
        end
        StAck: begin
          // A serializer that never reports busy is treated as having sent the byte.
          if (!tx_done_i) begin
            state_q <= StBusy;
          end else if (to_cnt_q == TW'(ACK_TO - 1)) begin
            state_q <= StIdle;
          end else begin
            to_cnt_q <= to_cnt_q + TW'(1);
          end
        end
        StBusy: begin
          if (tx_done_i) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign full_o     = full_q;
  assign empty_o    = empty_q;
  assign count_o    = count_q;
  assign ovf_o      = ovf_q;
  assign tx_data_o  = tx_data_q;
  assign tx_start_o = tx_start_q;

endmodule

// File: tb/tb_trace_fifo.sv
// Bench for trace_fifo: directed scenarios plus paced random streaming, all
// checked every cycle against a queue-based model of buffer and sequencer.
module tb_trace_fifo;

  localparam int DEPTH  = 16;
  localparam int WIDTH  = 8;
  localparam int ACK_TO = 64;

  logic             clk = 1'b0;
  logic             rst, wr_en, ovf_clr, tx_done;
  logic [WIDTH-1:0] wr_data;
  logic             full_o, empty_o, ovf_o, tx_start_o;
  logic [4:0]       count_o;
  logic [WIDTH-1:0] tx_data_o;

  trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .ACK_TO(ACK_TO)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .wr_en_i   (wr_en),
    .wr_data_i (wr_data),
    .full_o    (full_o),
    .empty_o   (empty_o),
    .count_o   (count_o),
    .ovf_o     (ovf_o),
    .ovf_clr_i (ovf_clr),
    .tx_data_o (tx_data_o),
    .tx_start_o(tx_start_o),
    .tx_done_i (tx_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model: byte queue plus an abstract "sequencer ready" view.
  logic [7:0] mq[$];
  bit         m_ready, m_acked, m_ovf, m_start;
  int         m_wait;
  logic [7:0] m_data;

  // Bench serializer: 0 = busy for busy_len cycles, 1 = stuck busy, 2 = never busy.
  int ser_mode, busy_len, busy_left;
  bit ser_done;

  logic [7:0] seen[$];
  int         seen_t[$];
  int         maxc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_edge(input bit r, input bit w, input logic [7:0] d, input bit clr,
                            input bit done);
    int s;
    bit dropped;
    if (r) begin
      mq.delete();
      m_ready = 1; m_acked = 0; m_wait = 0; m_ovf = 0; m_data = 8'h00; m_start = 0;
    end else begin
      s = mq.size();
      m_start = 0;
      if (m_ready && s > 0 && done) begin
        m_data  = mq.pop_front();
        m_start = 1;
        m_ready = 0; m_acked = 0; m_wait = 0;
      end else if (!m_ready) begin
        if (!m_acked) begin
          if (!done) m_acked = 1;
          else begin
            m_wait++;
            if (m_wait == ACK_TO) m_ready = 1;
          end
        end else if (done) begin
          m_ready = 1;
        end
      end
      dropped = w && (s == DEPTH);
      if (w && !dropped) mq.push_back(d);
      if (dropped) m_ovf = 1;
      else if (clr) m_ovf = 0;
    end
  endtask

  task automatic step(input bit r, input bit w, input logic [7:0] d, input bit clr);
    rst = r; wr_en = w; wr_data = d; ovf_clr = clr; tx_done = ser_done;
    @(posedge clk);
    model_edge(r, w, d, clr, ser_done);
    #1;
    cyc++;
    check("count", 32'(count_o), mq.size());
    check("empty", empty_o, mq.size() == 0);
    check("full", full_o, mq.size() == DEPTH);
    check("ovf", ovf_o, m_ovf);
    check("start", tx_start_o, m_start);
    check("data", tx_data_o, m_data);
    if (int'(count_o) > maxc) maxc = int'(count_o);
    if (tx_start_o === 1'b1) begin
      seen.push_back(tx_data_o);
      seen_t.push_back(cyc);
    end
    if (r) busy_left = 0;
    case (ser_mode)
      0: begin
        if (m_start) busy_left = busy_len;
        else if (busy_left > 0) busy_left--;
        ser_done = (busy_left == 0);
      end
      1:       ser_done = 0;
      default: ser_done = 1;
    endcase
  endtask

  initial begin
    int sent;
    rst = 1; wr_en = 0; wr_data = 0; ovf_clr = 0; tx_done = 1;
    ser_mode = 0; busy_len = 10; busy_left = 0; ser_done = 1;
    m_ready = 1; m_acked = 0; m_wait = 0; m_ovf = 0; m_start = 0; m_data = 0;
    maxc = 0;

    // Reset held two cycles
    step(1, 0, 8'h00, 0);
    step(1, 0, 8'h00, 0);
    check("rst_empty", empty_o, 1);
    check("rst_start", tx_start_o, 0);

    // Three bytes through a 10-cycle serializer
    seen.delete();
    step(0, 1, 8'h41, 0);
    step(0, 1, 8'h42, 0);
    step(0, 1, 8'h43, 0);
    repeat (60) step(0, 0, 8'h00, 0);
    check("t2_nstarts", seen.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < seen.size()) check("t2_byte", seen[i], 8'h41 + i);
    end
    check("t2_empty", empty_o, 1);

    // Serializer stuck busy: fill, overflow, clear, set-beats-clear
    ser_mode = 1; ser_done = 0;
    for (int i = 0; i < DEPTH; i++) step(0, 1, 8'(8'h80 + i), 0);
    check("t3_full", full_o, 1);
    check("t3_count", 32'(count_o), 16);
    step(0, 1, 8'hEE, 0);
    check("t3_ovf_set", ovf_o, 1);
    step(0, 0, 8'h00, 1);
    check("t3_ovf_clr", ovf_o, 0);
    step(0, 1, 8'hEF, 1);
    check("t3_set_wins", ovf_o, 1);

    // Push and pop together at count 5, then at full
    step(1, 0, 8'h00, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 8'(8'h50 + i), 0);
    ser_mode = 0; ser_done = 1; busy_len = 4;
    step(0, 1, 8'h55, 0);
    check("t5_count5", 32'(count_o), 5);
    check("t5_start", tx_start_o, 1);
    repeat (80) step(0, 0, 8'h00, 0);
    ser_mode = 1; ser_done = 0;
    for (int i = 0; i < DEPTH; i++) step(0, 1, 8'(8'h60 + i), 0);
    ser_mode = 0; ser_done = 1;
    step(0, 1, 8'hAA, 0);
    check("t5_full_ovf", ovf_o, 1);
    check("t5_full_count", 32'(count_o), 15);
    repeat (200) step(0, 0, 8'h00, 1);

    // Paced random stream 0x00..0x27 with random serializer busy time
    seen.delete();
    maxc = 0;
    sent = 0;
    for (int c = 0; c < 700; c++) begin
      busy_len = $urandom_range(1, 5);
      if (sent < 40 && mq.size() < DEPTH && $urandom_range(0, 2) != 0) begin
        step(0, 1, sent[7:0], 0);
        sent++;
      end else begin
        step(0, 0, 8'h00, 0);
      end
    end
    check("t4_nbytes", seen.size(), 40);
    for (int i = 0; i < 40; i++) begin
      if (i < seen.size()) check("t4_order", seen[i], i);
    end
    check("t4_max_le_depth", maxc <= DEPTH, 1);

    // Serializer never goes busy: ack timeout spaces the two starts
    ser_mode = 2; ser_done = 1;
    seen.delete(); seen_t.delete();
    step(0, 1, 8'hC0, 0);
    step(0, 1, 8'hC1, 0);
    repeat (200) step(0, 0, 8'h00, 0);
    check("t6_nstarts", seen_t.size(), 2);
    // ACK_TO waiting cycles in ACK, then one IDLE cycle to pop
    if (seen_t.size() >= 2) check("t6_gap", seen_t[1] - seen_t[0], ACK_TO + 1);

    // Reset while the serializer is busy
    ser_mode = 0; busy_len = 20;
    step(0, 1, 8'hD0, 0);
    step(0, 1, 8'hD1, 0);
    step(0, 1, 8'hD2, 0);
    repeat (4) step(0, 0, 8'h00, 0);
    step(1, 0, 8'h00, 0);
    check("t6_rst_empty", empty_o, 1);
    check("t6_rst_count", 32'(count_o), 0);
    step(0, 1, 8'hE5, 0);
    step(0, 0, 8'h00, 0);
    check("t6_post_start", tx_start_o, 1);
    check("t6_post_data", tx_data_o, 8'hE5);
    repeat (30) step(0, 0, 8'h00, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
